// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - shared constants and state type for the SPI NOR flash reader
package flash_pkg;

   localparam int AddressWidth = 24;
   localparam int CommandWidth = 8;
   localparam logic [CommandWidth-1:0] CmdRead = 8'h03;

   typedef enum logic [2:0] {
      Idle,
      SendCommand,
      SendAddress,
      ReceiveData,
      Recover
   } state_e;

endpackage

// File: rtl/spi_bit_engine.sv
// rtl/spi_bit_engine.sv - mode 0 SPI bit engine: 2-cycle bit period, 8-bit tx/rx shift, byte boundary pause
module spi_bit_engine (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic       run_i,
   input  logic       pause_i,
   input  logic [7:0] tx_byte_i,
   input  logic       miso_i,
   output logic       sclk_o,
   output logic       mosi_o,
   output logic       byte_done_o,
   output logic [7:0] rx_byte_o
);

   logic       phase_q, phase_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] rx_q, rx_d;
   logic       stall;

   // A pause can only take effect before the first bit of a byte, so bytes are never split.
   assign stall       = pause_i && !phase_q && (bit_cnt_q == 3'd0);
   assign byte_done_o = run_i && phase_q && (bit_cnt_q == 3'd7);
   assign sclk_o      = phase_q;
   assign mosi_o      = tx_q[7];
   assign rx_byte_o   = rx_q;

   always_comb begin
      phase_d   = phase_q;
      bit_cnt_d = bit_cnt_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      if (load_i) begin
         tx_d      = tx_byte_i;
         phase_d   = 1'b0;
         bit_cnt_d = 3'd0;
      end else if (run_i && !stall) begin
         if (!phase_q) begin
            phase_d = 1'b1;
         end else begin
            phase_d = 1'b0;
            rx_d    = {rx_q[6:0], miso_i};
            if (bit_cnt_q == 3'd7) begin
               bit_cnt_d = 3'd0;
               tx_d      = tx_byte_i;
            end else begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               tx_d      = {tx_q[6:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q   <= 1'b0;
         bit_cnt_q <= 3'd0;
         tx_q      <= 8'h00;
         rx_q      <= 8'h00;
      end else begin
         phase_q   <= phase_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
      end
   end

endmodule

// File: rtl/flash_reader.sv
// rtl/flash_reader.sv - streams bytes from SPI NOR flash (READ 0x03) onto a valid/ready byte stream
module flash_reader
   import flash_pkg::*;
#(
   parameter int ByteCountWidth = 16,
   parameter int CsHighCycles   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [AddressWidth-1:0]   start_address,
   input  logic [ByteCountWidth-1:0] byte_count,
   output logic                      busy,
   output logic                      done,
   output logic [7:0]                data_out,
   output logic                      data_valid,
   input  logic                      data_ready,
   output logic                      flash_clk,
   output logic                      flash_mosi,
   input  logic                      flash_miso,
   output logic                      flash_cs_n
);

   localparam int RecWidth = $clog2(CsHighCycles + 1);

   state_e                    state_q, state_d;
   logic [AddressWidth-1:0]   addr_q, addr_d;
   logic [ByteCountWidth-1:0] count_q, count_d;
   logic [1:0]                addr_byte_q, addr_byte_d;
   logic [RecWidth-1:0]       rec_q, rec_d;
   logic                      done_q, done_d;
   logic                      pending_q, pending_d;
   logic                      valid_q, valid_d;
   logic [7:0]                data_q, data_d;

   logic       eng_load, eng_run, eng_pause, byte_done, handshake;
   logic [7:0] eng_tx, eng_rx;

   assign eng_run    = (state_q == SendCommand) || (state_q == SendAddress) || (state_q == ReceiveData);
   // The shift register holds one finished byte; stop before a second would land on an unconsumed one.
   assign eng_pause  = (state_q == ReceiveData) && valid_q && !data_ready;
   // addr_q is consumed MSB byte first and zero-fills, so mosi drops to 0 once the address is out.
   assign eng_tx     = (state_q == Idle) ? CmdRead : addr_q[AddressWidth-1 -: 8];
   assign handshake  = valid_q && data_ready;

   assign flash_cs_n = !eng_run;
   assign busy       = (state_q != Idle);
   assign done       = done_q;
   assign data_out   = data_q;
   assign data_valid = valid_q;

   spi_bit_engine u_engine (
      .clk         (clk),
      .rst         (rst),
      .load_i      (eng_load),
      .run_i       (eng_run),
      .pause_i     (eng_pause),
      .tx_byte_i   (eng_tx),
      .miso_i      (flash_miso),
      .sclk_o      (flash_clk),
      .mosi_o      (flash_mosi),
      .byte_done_o (byte_done),
      .rx_byte_o   (eng_rx)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      count_d     = count_q;
      addr_byte_d = addr_byte_q;
      rec_d       = rec_q;
      done_d      = 1'b0;
      eng_load    = 1'b0;
      case (state_q)
         Idle: begin
            if (start) begin
               if (byte_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  addr_d   = start_address;
                  count_d  = byte_count;
                  eng_load = 1'b1;
                  state_d  = SendCommand;
               end
            end
         end
         SendCommand: begin
            if (byte_done) begin
               addr_d      = {addr_q[AddressWidth-CommandWidth-1:0], {CommandWidth{1'b0}}};
               addr_byte_d = 2'd0;
               state_d     = SendAddress;
            end
         end
         SendAddress: begin
            if (byte_done) begin
               addr_d      = {addr_q[AddressWidth-CommandWidth-1:0], {CommandWidth{1'b0}}};
               addr_byte_d = addr_byte_q + 2'd1;
               if (addr_byte_q == 2'd2) begin
                  state_d = ReceiveData;
               end
            end
         end
         ReceiveData: begin
            if (byte_done) begin
               count_d = count_q - 1'b1;
               if (count_q == ByteCountWidth'(1)) begin
                  rec_d   = '0;
                  state_d = Recover;
               end
            end
         end
         Recover: begin
            if (rec_q == RecWidth'(CsHighCycles - 1)) begin
               done_d  = 1'b1;
               state_d = Idle;
            end else begin
               rec_d = rec_q + 1'b1;
            end
         end
         default: state_d = Idle;
      endcase
   end

   // Finished bytes wait one cycle in the shift register, then move to data_out once it is free.
   always_comb begin
      pending_d = pending_q;
      valid_d   = valid_q;
      data_d    = data_q;
      if (pending_q && (!valid_q || handshake)) begin
         data_d    = eng_rx;
         valid_d   = 1'b1;
         pending_d = 1'b0;
      end else if (handshake) begin
         valid_d = 1'b0;
      end
      if (byte_done && (state_q == ReceiveData)) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= Idle;
         addr_q      <= '0;
         count_q     <= '0;
         addr_byte_q <= 2'd0;
         rec_q       <= '0;
         done_q      <= 1'b0;
         pending_q   <= 1'b0;
         valid_q     <= 1'b0;
         data_q      <= 8'h00;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         addr_byte_q <= addr_byte_d;
         rec_q       <= rec_d;
         done_q      <= done_d;
         pending_q   <= pending_d;
         valid_q     <= valid_d;
         data_q      <= data_d;
      end
   end

endmodule

// File: tb/tb_flash_reader.sv
// tb/tb_flash_reader.sv - directed bench for flash_reader with a 256-byte SPI flash model (image byte i = i)
module tb_flash_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [23:0] start_address = 24'h0;
   logic [15:0] byte_count = 16'h0;
   logic        busy, done, data_valid;
   logic [7:0]  data_out;
   logic        data_ready = 1'b1;
   logic        flash_clk, flash_mosi, flash_cs_n;
   logic        flash_miso = 1'b0;

   int checks = 0;
   int errors = 0;

   flash_reader dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .start_address (start_address),
      .byte_count    (byte_count),
      .busy          (busy),
      .done          (done),
      .data_out      (data_out),
      .data_valid    (data_valid),
      .data_ready    (data_ready),
      .flash_clk     (flash_clk),
      .flash_mosi    (flash_mosi),
      .flash_miso    (flash_miso),
      .flash_cs_n    (flash_cs_n)
   );

   always #5 clk = ~clk;

   // Flash model: samples mosi on rising sclk, shifts data out on falling sclk after 32 header bits.
   int          f_cnt = 0;
   logic [31:0] f_sh = 32'h0;
   logic [7:0]  f_addr = 8'h0;
   logic [2:0]  f_bit = 3'd0;
   logic [7:0]  last_cmd = 8'h0;
   logic [23:0] last_addr = 24'h0;
   int          data_rises = 0;

   always @(posedge flash_clk or negedge flash_clk or posedge flash_cs_n) begin
      if (flash_cs_n) begin
         f_cnt <= 0;
         f_bit <= 3'd0;
      end else if (flash_clk) begin
         if (f_cnt < 32) begin
            f_sh  <= {f_sh[30:0], flash_mosi};
            f_cnt <= f_cnt + 1;
            if (f_cnt == 31) begin
               last_cmd  <= f_sh[30:23];
               last_addr <= {f_sh[22:0], flash_mosi};
               f_addr    <= {f_sh[6:0], flash_mosi};
            end
         end else begin
            data_rises <= data_rises + 1;
         end
      end else if (f_cnt == 32) begin
         flash_miso <= f_addr[~f_bit];
         f_bit      <= f_bit + 3'd1;
         if (f_bit == 3'd7) f_addr <= f_addr + 8'd1;
      end
   end

   int         rx_n = 0;
   logic [7:0] rx_log [0:255];
   int         done_total = 0;
   int         cs_run = 0;
   int         cs_run_at_done = 0;
   int         cs_fall_total = 0;
   int         clk_rise_total = 0;
   int         busy_rise_total = 0;
   int         hs_rises = 0;
   int         max_gap = 0;
   logic       cs_prev = 1'b1, fclk_prev = 1'b0, busy_prev = 1'b0;

   always @(posedge clk) begin
      if (data_valid && data_ready) begin
         rx_log[rx_n[7:0]] <= data_out;
         rx_n              <= rx_n + 1;
         hs_rises          <= data_rises;
      end
      if (done) begin
         done_total     <= done_total + 1;
         cs_run_at_done <= cs_run;
      end
      cs_run <= flash_cs_n ? cs_run + 1 : 0;
      if (cs_prev && !flash_cs_n) cs_fall_total <= cs_fall_total + 1;
      if (!fclk_prev && flash_clk) clk_rise_total <= clk_rise_total + 1;
      if (!busy_prev && busy) busy_rise_total <= busy_rise_total + 1;
      if (data_rises - hs_rises > max_gap) max_gap <= data_rises - hs_rises;
      cs_prev   <= flash_cs_n;
      fclk_prev <= flash_clk;
      busy_prev <= busy;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic start_xfer(input logic [23:0] a, input logic [15:0] c);
      start         = 1'b1;
      start_address = a;
      byte_count    = c;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k;
      k = 0;
      while (!done && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(tag, done, 1'b1);
   endtask

   task automatic check_stream(input string tag, input int base, input int n, input logic [7:0] first);
      logic [7:0] exp;
      exp = first;
      for (int i = 0; i < n; i++) begin
         check(tag, rx_log[(base + i) % 256], exp);
         exp = exp + 8'd1;
      end
   endtask

   initial begin
      int n, r0, d0, cs0, ck0, bz0;

      tick(3);
      check("rst_cs_n", flash_cs_n, 1'b1);
      check("rst_sclk", flash_clk, 1'b0);
      check("rst_mosi", flash_mosi, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_valid", data_valid, 1'b0);
      check("rst_data", data_out, 8'h00);
      rst = 1'b0;
      tick(2);

      // Basic 4-byte read from 0x10 with the consumer always ready.
      r0 = rx_n; d0 = done_total;
      start_xfer(24'h000010, 16'd4);
      check("t1_busy", busy, 1'b1);
      check("t1_cs_low", flash_cs_n, 1'b0);
      n = 0;
      while (!data_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("t1_first_valid_cycle", n, 81);
      wait_done("t1_done", 300);
      tick(10);
      check("t1_cmd", last_cmd, 8'h03);
      check("t1_addr", last_addr, 24'h000010);
      check("t1_count", rx_n - r0, 4);
      check_stream("t1_byte", r0, 4, 8'h10);
      check("t1_done_once", done_total - d0, 1);
      check("t1_cs_high_ge4", cs_run_at_done >= 4, 1'b1);
      check("t1_busy_clear", busy, 1'b0);

      // Zero-length request: immediate done, bus untouched.
      cs0 = cs_fall_total; ck0 = clk_rise_total; bz0 = busy_rise_total;
      start_xfer(24'h000040, 16'd0);
      check("t2_done", done, 1'b1);
      check("t2_busy", busy, 1'b0);
      tick(1);
      check("t2_done_pulse", done, 1'b0);
      tick(5);
      check("t2_cs_untouched", cs_fall_total - cs0, 0);
      check("t2_sclk_untouched", clk_rise_total - ck0, 0);
      check("t2_busy_untouched", busy_rise_total - bz0, 0);

      // Backpressure with ready toggling every 20 cycles; flash wraps at 256 bytes.
      r0 = rx_n; d0 = done_total;
      start_xfer(24'h0000FE, 16'd3);
      n = 0;
      while (!done && n < 800) begin
         @(negedge clk);
         n++;
         if (n % 20 == 0) data_ready = ~data_ready;
      end
      check("t3_done", done, 1'b1);
      data_ready = 1'b1;
      tick(5);
      check("t3_count", rx_n - r0, 3);
      check("t3_b0", rx_log[r0 % 256], 8'hFE);
      check("t3_b1", rx_log[(r0 + 1) % 256], 8'hFF);
      check("t3_b2", rx_log[(r0 + 2) % 256], 8'h00);
      check("t3_no_overrun", max_gap <= 16, 1'b1);
      check("t3_done_once", done_total - d0, 1);

      // A second start during a transfer is ignored.
      r0 = rx_n; d0 = done_total;
      start_xfer(24'h000040, 16'd2);
      tick(29);
      start_xfer(24'h000080, 16'd5);
      wait_done("t4_done", 300);
      tick(10);
      check("t4_addr", last_addr, 24'h000040);
      check("t4_count", rx_n - r0, 2);
      check_stream("t4_byte", r0, 2, 8'h40);
      check("t4_done_once", done_total - d0, 1);
      check("t4_idle", busy, 1'b0);

      // Reset during the second data byte aborts without done.
      d0 = done_total; r0 = rx_n;
      start_xfer(24'h000050, 16'd4);
      n = 0;
      while (rx_n == r0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("t5_first_byte", rx_log[r0 % 256], 8'h50);
      tick(4);
      rst = 1'b1;
      @(negedge clk);
      check("t5_cs_n", flash_cs_n, 1'b1);
      check("t5_sclk", flash_clk, 1'b0);
      check("t5_valid", data_valid, 1'b0);
      check("t5_busy", busy, 1'b0);
      rst = 1'b0;
      tick(5);
      check("t5_no_done", done_total - d0, 0);
      r0 = rx_n;
      start_xfer(24'h000020, 16'd1);
      wait_done("t5_restart_done", 300);
      tick(5);
      check("t5_restart_count", rx_n - r0, 1);
      check("t5_restart_byte", rx_log[r0 % 256], 8'h20);

      // Final byte left unaccepted past done.
      r0 = rx_n;
      data_ready = 1'b0;
      start_xfer(24'h000033, 16'd1);
      n = 0;
      while (!done && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("t6_done", done, 1'b1);
      check("t6_valid_at_done", data_valid, 1'b1);
      check("t6_data_at_done", data_out, 8'h33);
      while (n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t6_still_held", data_valid, 1'b1);
      check("t6_busy_low", busy, 1'b0);
      data_ready = 1'b1;
      @(negedge clk);
      check("t6_valid_cleared", data_valid, 1'b0);
      check("t6_count", rx_n - r0, 1);
      check("t6_byte", rx_log[r0 % 256], 8'h33);
      check("t6_busy_after", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
